// File: rtl/phy_stripe_n.sv
// Byte striper for the PHY transmit path: gathers a single-lane byte stream into
// groups of up to NUM_LANES symbols and presents each group in parallel for one cycle.
module phy_stripe_n #(
  parameter int                NUM_LANES     = 4,
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM      = DATA_W'(8'hBC),
  parameter int                FLUSH_TIMEOUT = 8,
  parameter int                CNT_W         = 16
) (
  input  logic                        clk_8f,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  input  logic [3:0]                  active_lanes,
  output logic [NUM_LANES*DATA_W-1:0] data_out,
  output logic [NUM_LANES-1:0]        valid_out,
  output logic                        group_valid,
  output logic                        partial,
  output logic [CNT_W-1:0]            group_count
);

  typedef enum logic {ST_IDLE, ST_FILL} state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  fill_q, fill_d;
  logic [3:0]                  n_eff_q, n_eff_d;
  logic [7:0]                  idle_q, idle_d;
  logic [DATA_W-1:0]           shadow_q [NUM_LANES];
  logic [DATA_W-1:0]           shadow_d [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] data_out_q, data_out_d;
  logic [NUM_LANES-1:0]        valid_out_q, valid_out_d;
  logic                        group_valid_q, group_valid_d;
  logic                        partial_q, partial_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic [3:0] n_sel;
  logic [3:0] idx;
  logic [3:0] emit_n;
  logic       emit;

  always_comb begin
    n_sel = (active_lanes == 4'd0 || active_lanes > 4'(NUM_LANES)) ? 4'(NUM_LANES)
                                                                   : active_lanes;
    idx       = (state_q == ST_IDLE) ? 4'd0 : fill_q;
    state_d   = state_q;
    fill_d    = fill_q;
    n_eff_d   = n_eff_q;
    idle_d    = idle_q;
    shadow_d  = shadow_q;
    count_d   = count_q;
    partial_d = 1'b0;
    emit      = 1'b0;
    emit_n    = 4'd0;

    if (valid_in) begin
      // Lane count is frozen at the first byte of a group.
      if (state_q == ST_IDLE) n_eff_d = n_sel;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (4'(k) == idx) shadow_d[k] = data_in;
      end
      idle_d = 8'd0;
      if (idx + 4'd1 == n_eff_d) begin
        emit    = 1'b1;
        emit_n  = n_eff_d;
        state_d = ST_IDLE;
        fill_d  = 4'd0;
      end else begin
        state_d = ST_FILL;
        fill_d  = idx + 4'd1;
      end
    end else if (state_q == ST_FILL) begin
      idle_d = idle_q + 8'd1;
      if (FLUSH_TIMEOUT != 0 && ({1'b0, idle_q} + 9'd1) == 9'(FLUSH_TIMEOUT)) begin
        emit      = 1'b1;
        emit_n    = fill_q;
        partial_d = 1'b1;
        state_d   = ST_IDLE;
        fill_d    = 4'd0;
        idle_d    = 8'd0;
      end
    end else begin
      idle_d = 8'd0;
    end

    // Outputs never hold a previous group: non-emit cycles present idle symbols.
    for (int k = 0; k < NUM_LANES; k++) begin
      valid_out_d[k]                 = emit && (4'(k) < emit_n);
      data_out_d[k*DATA_W +: DATA_W] = valid_out_d[k] ? shadow_d[k] : IDLE_SYM;
    end
    group_valid_d = emit;
    if (emit) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      fill_q        <= 4'd0;
      n_eff_q       <= 4'd0;
      idle_q        <= 8'd0;
      for (int k = 0; k < NUM_LANES; k++) shadow_q[k] <= '0;
      data_out_q    <= {NUM_LANES{IDLE_SYM}};
      valid_out_q   <= '0;
      group_valid_q <= 1'b0;
      partial_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      n_eff_q       <= n_eff_d;
      idle_q        <= idle_d;
      for (int k = 0; k < NUM_LANES; k++) shadow_q[k] <= shadow_d[k];
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      group_valid_q <= group_valid_d;
      partial_q     <= partial_d;
      count_q       <= count_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign group_valid = group_valid_q;
  assign partial     = partial_q;
  assign group_count = count_q;

endmodule

// File: tb/tb_phy_stripe_n.sv
// Bench for phy_stripe_n: a byte-level model pushes expected groups as stimulus is
// driven; a negedge monitor pops and compares each emitted group and checks idle cycles.
module tb_phy_stripe_n;
  localparam int          NL   = 4;
  localparam int          DW   = 8;
  localparam int          TO   = 8;
  localparam int          CW   = 4;
  localparam logic [7:0]  IDLE = 8'hBC;
  localparam int          EW   = 57;

  logic             clk_8f = 1'b0;
  logic             reset;
  logic [DW-1:0]    data_in;
  logic             valid_in;
  logic [3:0]       active_lanes;
  logic [NL*DW-1:0] data_out;
  logic [NL-1:0]    valid_out;
  logic             group_valid;
  logic             partial;
  logic [CW-1:0]    group_count;

  phy_stripe_n #(
    .NUM_LANES(NL), .DATA_W(DW), .IDLE_SYM(IDLE), .FLUSH_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .active_lanes(active_lanes), .data_out(data_out), .valid_out(valid_out),
    .group_valid(group_valid), .partial(partial), .group_count(group_count)
  );

  // clock / cycle counter
  always #5 clk_8f = ~clk_8f;
  int cyc = 0;
  always @(posedge clk_8f) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // byte-level reference model
  int         m_fill = 0;
  int         m_n    = 0;
  int         m_idle = 0;
  logic [7:0] m_sh [NL];
  logic [CW-1:0] m_count = '0;

  task automatic push_group(input int n, input logic part);
    logic [NL*DW-1:0] d;
    logic [NL-1:0]    v;
    for (int k = 0; k < NL; k++) begin
      v[k]          = (k < n);
      d[k*DW +: DW] = (k < n) ? m_sh[k] : IDLE;
    end
    m_count = m_count + 1'b1;
    exp_q.push_back({16'(cyc + 1), m_count, part, v, d});
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic [3:0] al);
    if (v) begin
      if (m_fill == 0) m_n = (al == 0 || al > NL) ? NL : int'(al);
      m_sh[m_fill] = d;
      m_fill++;
      m_idle = 0;
      if (m_fill == m_n) begin
        push_group(m_n, 1'b0);
        m_fill = 0;
      end
    end else if (m_fill > 0) begin
      m_idle++;
      if (TO > 0 && m_idle == TO) begin
        push_group(m_fill, 1'b1);
        m_fill = 0;
        m_idle = 0;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] al);
    @(negedge clk_8f);
    valid_in     = v;
    data_in      = d;
    active_lanes = al;
    model_step(v, d, al);
  endtask

  task automatic idle_n(input int n, input logic [3:0] al);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, al);
  endtask

  task automatic check_reset_values();
    check("rst_data", data_out, {NL{IDLE}});
    check("rst_valid", valid_out, 0);
    check("rst_gv", group_valid, 0);
    check("rst_partial", partial, 0);
    check("rst_count", group_count, 0);
  endtask

  // monitor
  logic [EW-1:0] e;
  always @(negedge clk_8f) begin
    if (mon_en) begin
      if (group_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_group", data_out, 0);
        end else begin
          e = exp_q.pop_front();
          check("emit_cycle", 64'(cyc), 64'(e[56:41]));
          check("grp_data", data_out, e[31:0]);
          check("grp_valid", valid_out, e[35:32]);
          check("grp_partial", partial, e[36]);
          check("grp_count", group_count, e[40:37]);
        end
      end else begin
        check("idle_data", data_out, {NL{IDLE}});
        check("idle_valid", valid_out, 0);
        check("idle_partial", partial, 0);
      end
    end
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; data_in = '0; active_lanes = 4'd4;
    repeat (3) @(posedge clk_8f);
    #1 check_reset_values();
    @(negedge clk_8f);
    reset  = 1'b1;
    mon_en = 1'b1;

    // full 4-lane group
    drive(1, 8'h11, 4); drive(1, 8'h22, 4); drive(1, 8'h33, 4); drive(1, 8'h44, 4);
    idle_n(2, 4);

    // two back-to-back 2-lane groups
    drive(1, 8'hA1, 2); drive(1, 8'hA2, 2); drive(1, 8'hA3, 2); drive(1, 8'hA4, 2);
    idle_n(2, 2);

    // timeout flush of a 2-byte partial group
    drive(1, 8'h55, 4); drive(1, 8'h66, 4);
    idle_n(10, 4);

    // byte on the would-be timeout edge suppresses the flush
    drive(1, 8'h55, 4); drive(1, 8'h66, 4);
    idle_n(7, 4);
    drive(1, 8'h77, 4);
    idle_n(3, 4);
    drive(1, 8'h88, 4);
    idle_n(2, 4);

    // lane-count change mid-group is ignored until the next group
    drive(1, 8'h91, 4); drive(1, 8'h92, 1); drive(1, 8'h93, 1); drive(1, 8'h94, 1);
    drive(1, 8'h9A, 1);
    idle_n(2, 1);

    // reset mid-group discards stale bytes and clears the count
    drive(1, 8'hE1, 4); drive(1, 8'hE2, 4); drive(1, 8'hE3, 4);
    @(negedge clk_8f);
    reset = 1'b0; valid_in = 1'b0;
    m_fill = 0; m_idle = 0; m_count = '0;
    #1 check_reset_values();
    repeat (2) @(negedge clk_8f);
    reset = 1'b1;
    drive(1, 8'h01, 4); drive(1, 8'h02, 4); drive(1, 8'h03, 4); drive(1, 8'h04, 4);
    idle_n(2, 4);

    // 1-lane groups every cycle: count wraps through 15 -> 0
    for (int i = 0; i < 18; i++) drive(1, 8'(8'hC0 + i), 1);
    // active_lanes = 0 and > NUM_LANES clamp to four lanes
    drive(1, 8'hD1, 0); drive(1, 8'hD2, 0); drive(1, 8'hD3, 0); drive(1, 8'hD4, 0);
    drive(1, 8'hD5, 9); drive(1, 8'hD6, 9); drive(1, 8'hD7, 9); drive(1, 8'hD8, 9);
    idle_n(2, 4);

    // random traffic with occasional long idle gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) idle_n($urandom_range(6, 10), 4'($urandom_range(0, 15)));
      else drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)));
    end
    idle_n(12, 4);

    check("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_stripe_n.md
Name: phy_stripe_n

Overview:
- Parametrised next-generation byte striper for the PHY transmit path.
- Gathers a single-lane byte stream (one byte per clk_8f cycle, qualified by valid) into a group of up to NUM_LANES bytes.
- Emits the whole group in parallel on NUM_LANES output lanes with per-lane valids.
- Adds features the two-lane PHY lacks: runtime-selectable active lane count, idle-symbol fill, timeout flush of partial groups, and a group counter.

Parameters:
- DATA_W, 8, bits per lane symbol.
- NUM_LANES, 4, physical output lanes; legal range 2..8.
- IDLE_SYM, 8'hBC, symbol driven on lanes carrying no valid data; width DATA_W.
- FLUSH_TIMEOUT, 8, consecutive idle input cycles before a partial group is flushed; 0 disables flush; legal range 0..255.
- CNT_W, 16, width of the group counter.

Ports:
- clk_8f  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  input byte.
- valid_in  input  1  data_in is valid this cycle; always accepted, no backpressure.
- active_lanes  input  4  lanes used per group.
- data_out  output  NUM_LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- valid_out  output  NUM_LANES  per-lane valid.
- group_valid  output  1  one-cycle pulse when a group is presented.
- partial  output  1  high with group_valid when the group was flushed short.
- group_count  output  CNT_W  number of groups emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every data_out lane = IDLE_SYM; valid_out = 0; group_valid = 0; partial = 0; group_count = 0.
  - Fill index, idle counter and FSM cleared; any partial group is discarded.
  - Release is effective on the first rising edge with reset=1.
- FSM has two states:
  - IDLE: fill index = 0.
  - FILL: 0 < fill index < N_eff.
- N_eff (effective lane count):
  - Latched from active_lanes on the edge that accepts the first byte of a group (IDLE with valid_in=1).
  - Values 0 or >NUM_LANES clamp to NUM_LANES; active_lanes=1 is legal.
  - Changes to active_lanes during FILL are ignored until the next group.
- Accepting a byte (valid_in=1):
  - The byte is written to shadow lane [fill index] and the fill index increments.
  - The first byte of a group goes to lane 0.
- Group completion and emission:
  - When the byte making fill index == N_eff is accepted, the group is registered onto the outputs at that same edge, so it is visible in the following cycle (latency 1 cycle from the last byte).
  - On emission: valid_out[k] = 1 for k < N_eff and 0 otherwise; lanes k >= N_eff = IDLE_SYM; group_valid = 1 for exactly one cycle; group_count increments.
  - FSM returns to IDLE.
  - Back-to-back groups are allowed: with valid_in held high and N_eff=1, a group is emitted every cycle.
- Non-emit cycles: data_out = all IDLE_SYM, valid_out = 0, group_valid = 0, partial = 0. Outputs do not hold the previous group.
- Idle counter and timeout:
  - In FILL, each cycle with valid_in=0 increments the idle counter; a cycle with valid_in=1 clears it. The counter is cleared in IDLE.
  - When the counter reaches FLUSH_TIMEOUT (FLUSH_TIMEOUT>0), the partial group is emitted at that edge: valid_out[k] = 1 for k < fill index; remaining lanes = IDLE_SYM; group_valid = 1; partial = 1; group_count increments; FSM goes to IDLE.
  - If valid_in=1 on the edge where the timeout would fire, the byte is accepted and no flush occurs.
  - With FLUSH_TIMEOUT=0, a partial group waits indefinitely.
- group_count wrap: 2^CNT_W−1 → 0 with no flag.
- Reset asserted mid-group: outputs go to reset values immediately and no partial group is emitted afterwards.

Test Plan:
- Reset then NUM_LANES=4, active_lanes=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles → the cycle after 0x44: data_out=0x44332211, valid_out=4'b1111, group_valid=1, partial=0, group_count=1; the next cycle data_out=0xBCBCBCBC, valid_out=0.
- active_lanes=2, stream 0xA1,0xA2,0xA3,0xA4 continuously → two groups on consecutive emits: 0xBCBCA2A1 then 0xBCBCA4A3, valid_out=4'b0011 each, group_count=2.
- FLUSH_TIMEOUT=8, active_lanes=4, bytes 0x55,0x66 then valid_in=0 → 8 idle cycles later data_out=0xBCBC6655, valid_out=4'b0011, partial=1; with a third byte 0x77 on the 8th idle-counter edge → no flush, fill continues.
- active_lanes changed from 4 to 1 after the first byte of a group → current group still completes with 4 lanes; the next single byte 0x9A emits 0xBCBCBC9A, valid_out=4'b0001.
- Assert reset after 3 of 4 bytes, release, send 4 new bytes 0x01..0x04 → only 0x04030201 is emitted and group_count=1; stale bytes are never seen.
- CNT_W=4: emit 16 groups → group_count wraps 15→0; active_lanes=0 → treated as 4 lanes.
